// File: rtl/data_pilot_extract_if.sv
// Bus bundle for the receive-side data/pilot extractor.
// The FFT sample stream goes in, and the data and pilot streams come out.
interface data_pilot_extract_if #(
  parameter int DW = 8
);
  logic [DW-1:0] fft_din_re;
  logic [DW-1:0] fft_din_im;
  logic          fft_en;
  logic [5:0]    fft_index;
  logic          fft_start;
  logic [DW-1:0] data_dout_re;
  logic [DW-1:0] data_dout_im;
  logic          data_vld;
  logic [5:0]    data_index;
  logic [DW-1:0] pilot_dout_re;
  logic [DW-1:0] pilot_dout_im;
  logic          pilot_vld;
  logic [1:0]    pilot_index;
  logic          sym_done;

  modport master (
    output fft_din_re, fft_din_im, fft_en, fft_index, fft_start,
    input  data_dout_re, data_dout_im, data_vld, data_index,
    input  pilot_dout_re, pilot_dout_im, pilot_vld, pilot_index, sym_done
  );

  modport slave (
    input  fft_din_re, fft_din_im, fft_en, fft_index, fft_start,
    output data_dout_re, data_dout_im, data_vld, data_index,
    output pilot_dout_re, pilot_dout_im, pilot_vld, pilot_index, sym_done
  );
endinterface

// File: rtl/data_pilot_extract.sv
// Ping-pong buffers one 64-bin FFT symbol, then streams out 48 data carriers
// followed by 4 scrambler-polarity-corrected pilots.
module data_pilot_extract #(
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_pilot_extract_if.slave  bus
);
  typedef enum logic [0:0] {IDLE = 1'b0, DATA = 1'b1} state_t;

  state_t        state_r, state_s;
  logic [DW-1:0] mem_re [128];
  logic [DW-1:0] mem_im [128];
  logic          wbank_r, rbank_r, pol_r;
  logic [6:0]    scr_r;
  logic [5:0]    cnt_r, k1_r, k2_r;
  logic [6:0]    addr_r;
  logic          v1_r, v2_r;
  logic [DW-1:0] rd_re_r, rd_im_r;
  logic          eos_s, rd_go_s, scr_p_s, pneg_s, last_s;
  logic [DW-1:0] d_re_r, d_im_r, p_re_r, p_im_r;
  logic          d_vld_r, p_vld_r, done_r;
  logic [5:0]    d_idx_r;
  logic [1:0]    p_idx_r;

  function automatic logic [5:0] bin_of(input logic [5:0] k);
    logic [5:0] r;
    if (k < 6'd5)       r = k + 6'd38;
    else if (k < 6'd18) r = k + 6'd39;
    else if (k < 6'd24) r = k + 6'd40;
    else if (k < 6'd30) r = k - 6'd23;
    else if (k < 6'd43) r = k - 6'd22;
    else if (k < 6'd48) r = k - 6'd21;
    else begin
      case (k[1:0])
        2'd0:    r = 6'd43;
        2'd1:    r = 6'd57;
        2'd2:    r = 6'd7;
        default: r = 6'd21;
      endcase
    end
    return r;
  endfunction

  // Negating the most negative code would wrap, so clamp it to full scale.
  function automatic logic [DW-1:0] sat_neg(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    if (x == {1'b1, {(DW-1){1'b0}}}) r = {1'b0, {(DW-1){1'b1}}};
    else                             r = {DW{1'b0}} - x;
    return r;
  endfunction

  assign eos_s   = bus.fft_en && (bus.fft_index == 6'd63);
  assign scr_p_s = scr_r[6] ^ scr_r[3];
  assign pneg_s  = pol_r ^ (k2_r[1:0] == 2'd3);
  assign last_s  = v2_r && (k2_r == 6'd51);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  always_comb begin
    state_s = state_r;
    if (bus.fft_start) begin
      state_s = IDLE;
    end else if (eos_s) begin
      state_s = DATA;
    end else begin
      case (state_r)
        IDLE:    state_s = IDLE;
        DATA:    state_s = (cnt_r == 6'd51) ? IDLE : DATA;
        default: state_s = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_go_s = 1'b0;
    case (state_r)
      IDLE:    rd_go_s = 1'b0;
      DATA:    rd_go_s = 1'b1;
      default: rd_go_s = 1'b0;
    endcase
  end

  // A new end-of-symbol restarts readout on the bank just completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank_r <= 1'b0;
      rbank_r <= 1'b0;
      pol_r   <= 1'b0;
      cnt_r   <= 6'd0;
      scr_r   <= 7'h7F;
    end else if (bus.fft_start) begin
      wbank_r <= 1'b0;
      cnt_r   <= 6'd0;
      scr_r   <= 7'h7F;
    end else begin
      if (eos_s) begin
        wbank_r <= ~wbank_r;
        rbank_r <= wbank_r;
        pol_r   <= scr_p_s;
        cnt_r   <= 6'd0;
      end else if (rd_go_s) begin
        cnt_r   <= cnt_r + 6'd1;
      end
      if (last_s) scr_r <= {scr_r[5:0], scr_p_s};
    end
  end

  always_ff @(posedge clk) begin
    if (bus.fft_en) begin
      mem_re[{wbank_r, bus.fft_index}] <= bus.fft_din_re;
      mem_im[{wbank_r, bus.fft_index}] <= bus.fft_din_im;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      v2_r    <= 1'b0;
      k1_r    <= 6'd0;
      k2_r    <= 6'd0;
      addr_r  <= 7'd0;
      rd_re_r <= {DW{1'b0}};
      rd_im_r <= {DW{1'b0}};
    end else begin
      v1_r    <= rd_go_s && !bus.fft_start;
      v2_r    <= v1_r && !bus.fft_start;
      k1_r    <= cnt_r;
      k2_r    <= k1_r;
      addr_r  <= {rbank_r, bin_of(cnt_r)};
      rd_re_r <= mem_re[addr_r];
      rd_im_r <= mem_im[addr_r];
    end
  end

  // Output stage: values hold between valid cycles; fft_start clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.fft_start) begin
      d_re_r  <= {DW{1'b0}};
      d_im_r  <= {DW{1'b0}};
      d_vld_r <= 1'b0;
      d_idx_r <= 6'd0;
      p_re_r  <= {DW{1'b0}};
      p_im_r  <= {DW{1'b0}};
      p_vld_r <= 1'b0;
      p_idx_r <= 2'd0;
      done_r  <= 1'b0;
    end else begin
      d_vld_r <= 1'b0;
      p_vld_r <= 1'b0;
      done_r  <= last_s;
      if (v2_r && (k2_r < 6'd48)) begin
        d_vld_r <= 1'b1;
        d_idx_r <= k2_r;
        d_re_r  <= rd_re_r;
        d_im_r  <= rd_im_r;
      end else if (v2_r) begin
        p_vld_r <= 1'b1;
        p_idx_r <= k2_r[1:0];
        p_re_r  <= pneg_s ? sat_neg(rd_re_r) : rd_re_r;
        p_im_r  <= pneg_s ? sat_neg(rd_im_r) : rd_im_r;
      end
    end
  end

  assign bus.data_dout_re  = d_re_r;
  assign bus.data_dout_im  = d_im_r;
  assign bus.data_vld      = d_vld_r;
  assign bus.data_index    = d_idx_r;
  assign bus.pilot_dout_re = p_re_r;
  assign bus.pilot_dout_im = p_im_r;
  assign bus.pilot_vld     = p_vld_r;
  assign bus.pilot_index   = p_idx_r;
  assign bus.sym_done      = done_r;
endmodule

// File: tb/tb_data_pilot_extract.sv
// Scoreboard bench for data_pilot_extract: expected carriers are queued when a
// symbol's last bin is driven and compared, including arrival cycle, on output.
module tb_data_pilot_extract;
  typedef logic [7:0] sym_t [64];
  typedef struct {
    bit         pil;
    logic [5:0] idx;
    logic [7:0] re;
    logic [7:0] im;
    bit         last;
    int         cyc;
  } exp_t;
  typedef struct {
    bit         tx_p;
    logic [7:0] exp_re;
    logic [7:0] exp_im;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_pilot_extract_if #(.DW(8)) bus ();
  data_pilot_extract #(.DW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t       q[$];
  int         checks = 0;
  int         passed = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  logic [6:0] s_m;
  int         dbin[48];
  int         pbin[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input string detail);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic logic [7:0] sneg(input logic [7:0] x);
    return (x == 8'h80) ? 8'h7F : 8'h00 - x;
  endfunction

  function automatic bit outs_zero();
    return bus.data_dout_re == 8'h00 && bus.data_dout_im == 8'h00 && !bus.data_vld &&
           bus.data_index == 6'd0 && bus.pilot_dout_re == 8'h00 && bus.pilot_dout_im == 8'h00 &&
           !bus.pilot_vld && bus.pilot_index == 2'd0 && !bus.sym_done;
  endfunction

  function automatic string outs_str();
    return $sformatf("d=%h/%h v=%b i=%0d p=%h/%h v=%b i=%0d done=%b", bus.data_dout_re,
                     bus.data_dout_im, bus.data_vld, bus.data_index, bus.pilot_dout_re,
                     bus.pilot_dout_im, bus.pilot_vld, bus.pilot_index, bus.sym_done);
  endfunction

  // Output monitor: every valid beat must match the head of the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    bit   apil;
    logic [5:0] aidx;
    logic [7:0] are, aim;
    #1;
    if (rst_n) begin
      if (bus.sym_done) done_cnt++;
      if (bus.data_vld || bus.pilot_vld) begin
        apil = bus.pilot_vld;
        aidx = apil ? {4'd0, bus.pilot_index} : bus.data_index;
        are  = apil ? bus.pilot_dout_re : bus.data_dout_re;
        aim  = apil ? bus.pilot_dout_im : bus.data_dout_im;
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_out", $sformatf("got pil=%b idx=%0d at cyc %0d, required no output",
              apil, aidx, cyc));
        end else begin
          e = q.pop_front();
          chk(!(bus.data_vld && bus.pilot_vld) && apil == e.pil && aidx == e.idx && are == e.re &&
              aim == e.im && bus.sym_done == e.last && cyc == e.cyc, e.pil ? "pilot" : "data",
              $sformatf("got pil=%b idx=%0d re=%h im=%h done=%b cyc=%0d, required pil=%b idx=%0d re=%h im=%h done=%b cyc=%0d",
              apil, aidx, are, aim, bus.sym_done, cyc, e.pil, e.idx, e.re, e.im, e.last, e.cyc));
        end
      end else if (bus.sym_done) begin
        chk(1'b0, "sym_done_alone", $sformatf("got sym_done=1 without pilot_vld at cyc %0d, required 0", cyc));
      end
    end
  end

  task automatic push_sym(input sym_t re, input sym_t im, input bit use_exp, input logic [7:0] xre,
                          input logic [7:0] xim, input int eos);
    exp_t e;
    bit   p, neg;
    p   = s_m[6] ^ s_m[3];
    s_m = {s_m[5:0], p};
    for (int k = 0; k < 48; k++) begin
      e.pil = 1'b0; e.idx = 6'(k); e.re = re[dbin[k]]; e.im = im[dbin[k]];
      e.last = 1'b0; e.cyc = eos + 3 + k;
      q.push_back(e);
    end
    for (int j = 0; j < 4; j++) begin
      neg   = p ^ (j == 3);
      e.pil = 1'b1; e.idx = 6'(j);
      e.re  = use_exp ? xre : (neg ? sneg(re[pbin[j]]) : re[pbin[j]]);
      e.im  = use_exp ? xim : (neg ? sneg(im[pbin[j]]) : im[pbin[j]]);
      e.last = (j == 3); e.cyc = eos + 51 + j;
      q.push_back(e);
    end
  endtask

  task automatic send_sym(input sym_t re, input sym_t im, input bit use_exp, input logic [7:0] xre,
                          input logic [7:0] xim);
    for (int b = 0; b < 64; b++) begin
      @(negedge clk);
      bus.fft_en = 1'b1; bus.fft_index = 6'(b);
      bus.fft_din_re = re[b]; bus.fft_din_im = im[b];
      if (b == 63) push_sym(re, im, use_exp, xre, xim, cyc + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); bus.fft_en = 1'b0; end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 120 && q.size() != 0; i++) begin @(negedge clk); bus.fft_en = 1'b0; end
    chk(q.size() == 0, name, $sformatf("got %0d outputs still pending, required 0", q.size()));
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.fft_en = 1'b0; bus.fft_start = 1'b1;
    q.delete(); s_m = 7'h7F;
    @(negedge clk); bus.fft_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, required finish");
    $fatal(1);
  end

  initial begin
    sym_t re, im;
    vec_t vt[8];
    bit [7:0] pseq;
    bit seen;
    int n, d0;

    pseq = 8'b0111_0000;
    for (int t = 0; t < 8; t++) begin
      vt[t].tx_p = pseq[t]; vt[t].exp_re = 8'h40; vt[t].exp_im = 8'h00;
    end
    n = 0;
    for (int b = 38; b < 64; b++) if (b != 43 && b != 57) begin dbin[n] = b; n++; end
    for (int b = 1; b < 27; b++) if (b != 7 && b != 21) begin dbin[n] = b; n++; end
    pbin[0] = 43; pbin[1] = 57; pbin[2] = 7; pbin[3] = 21;

    rst_n = 1'b0; s_m = 7'h7F;
    bus.fft_en = 1'b0; bus.fft_index = 6'd0; bus.fft_start = 1'b0;
    bus.fft_din_re = 8'h00; bus.fft_din_im = 8'h00;
    repeat (3) @(negedge clk);
    chk(outs_zero(), "reset_state", {"got ", outs_str(), ", required all zero"});
    rst_n = 1'b1;

    // Bin-valued symbol: checks carrier order, pilot 21 negation and latency.
    pulse_start();
    for (int b = 0; b < 64; b++) begin re[b] = 8'(b); im[b] = ~8'(b); end
    send_sym(re, im, 1'b0, 8'h00, 8'h00);
    drain("bin_order_drain");

    // Eight pilot-clean symbols, transmitted with the scrambler polarity table.
    pulse_start();
    d0 = done_cnt;
    for (int t = 0; t < 8; t++) begin
      for (int b = 0; b < 64; b++) begin re[b] = 8'(b * 3 + t); im[b] = 8'(b + 17 * t); end
      for (int j = 0; j < 4; j++) begin
        re[pbin[j]] = (vt[t].tx_p ^ (j == 3)) ? 8'hC0 : 8'h40;
        im[pbin[j]] = 8'h00;
      end
      send_sym(re, im, 1'b1, vt[t].exp_re, vt[t].exp_im);
      idle(10);
    end
    drain("pilot_clean_drain");
    chk(done_cnt - d0 == 8, "sym_done_count", $sformatf("got %0d, required 8", done_cnt - d0));

    // Saturating negation of the most negative pilot value.
    pulse_start();
    for (int b = 0; b < 64; b++) begin re[b] = 8'(b + 100); im[b] = 8'(b ^ 8'h33); end
    re[21] = 8'h80; im[21] = 8'h05;
    send_sym(re, im, 1'b0, 8'h00, 8'h00);
    drain("saturation_drain");

    // Back-to-back symbols with alternating value sets.
    for (int b = 0; b < 64; b++) begin re[b] = 8'hA0 ^ 8'(b); im[b] = 8'h0F + 8'(b); end
    send_sym(re, im, 1'b0, 8'h00, 8'h00);
    for (int b = 0; b < 64; b++) begin re[b] = 8'h5F - 8'(b); im[b] = 8'hF0 ^ 8'(b * 5); end
    send_sym(re, im, 1'b0, 8'h00, 8'h00);
    drain("back_to_back_drain");

    // fft_start abort at data_index 20 of the fourth symbol.
    pulse_start();
    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < 64; b++) begin re[b] = 8'(b * 7 + t); im[b] = 8'(200 - b - t); end
      send_sym(re, im, 1'b0, 8'h00, 8'h00);
      if (t < 3) idle(10);
    end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); bus.fft_en = 1'b0;
      if (bus.data_vld && bus.data_index == 6'd20) seen = 1'b1;
    end
    chk(seen, "abort_reach_idx20", $sformatf("got seen=%b, required 1", seen));
    bus.fft_start = 1'b1; q.delete(); s_m = 7'h7F;
    @(negedge clk); bus.fft_start = 1'b0;
    chk(outs_zero(), "abort_outputs", {"got ", outs_str(), ", required all zero"});
    idle(3);
    for (int b = 0; b < 64; b++) begin re[b] = 8'(b) ^ 8'h5A; im[b] = 8'(b) + 8'h80; end
    send_sym(re, im, 1'b0, 8'h00, 8'h00);
    drain("after_abort_drain");

    // Asynchronous reset mid-readout, then a clean symbol with p=0.
    for (int b = 0; b < 64; b++) begin re[b] = 8'(b * 11); im[b] = 8'(b * 13); end
    send_sym(re, im, 1'b0, 8'h00, 8'h00);
    idle(20);
    rst_n = 1'b0;
    #1;
    chk(outs_zero(), "async_reset", {"got ", outs_str(), ", required all zero"});
    q.delete(); s_m = 7'h7F;
    @(negedge clk); rst_n = 1'b1;
    idle(2);
    for (int b = 0; b < 64; b++) begin re[b] = 8'hFF - 8'(b); im[b] = 8'(b) ^ 8'hC3; end
    send_sym(re, im, 1'b0, 8'h00, 8'h00);
    drain("after_reset_drain");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
